ekf_stage_sched: RTL and testbench
==================================

Name: ekf_stage_sched

Overview:
- Sequencer that sits in front of the EKF-SLAM Top core and drives its stage_val/stage_rdy handshake.
- Buffers host stage commands (PRD/NEW/UPD/ASSOC) in a small FIFO and issues them to the core one at a time.
- Owns the landmark_num register and checks each command's landmark index.
- Reports completion, rejection or timeout of every command on a status channel.

Parameters:
ROW_LEN, 10, width of landmark_num / l_k
LM_MAX, 1000, maximum landmark count; NEW is rejected at this value
FIFO_DEPTH, 4, command FIFO entries (power of 2)
VAL_HOLD, 2, cycles stage_val is held asserted per issue
TO_CYC, 4096, cycles to wait for stage_rdy before declaring timeout
TO_W, 13, timeout counter width (must hold TO_CYC)

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
cmd_val  in  1  host command valid
cmd_rdy  out  1  FIFO not full; command accepted when cmd_val&cmd_rdy
cmd_stage  in  3  stage code: 1 PRD, 2 NEW, 3 UPD, 4 ASSOC
cmd_lk  in  ROW_LEN  landmark index for UPD/ASSOC
stage_val  out  3  stage code to core; 0 when idle
stage_rdy  in  3  core completion code; equals the finished stage code, otherwise 0
l_k  out  ROW_LEN  landmark index to core, held stable from issue until done
landmark_num  out  ROW_LEN  current landmark count
busy  out  1  scheduler not in IDLE
sts_val  out  1  one-cycle status pulse
sts_stage  out  3  stage code of the finished command
sts_code  out  2  0 OK, 1 rejected, 2 timeout

Behaviour:
- Reset values: all outputs 0 except cmd_rdy=1. FIFO empty, landmark_num=0, state IDLE. Async reset asserted mid-operation aborts everything and emits no status.
- FIFO:
  - Accepts a command on cmd_val&cmd_rdy; cmd_rdy=0 when FIFO_DEPTH entries are held.
  - A simultaneous push and pop when full is not allowed (cmd_rdy is already 0). A push and pop in the same cycle at any other level keeps the count.
  - Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: when the FIFO is non-empty, pop the head and go to CHECK.
  - CHECK (1 cycle): the command is rejected if any of these holds:
    - stage code is 0 or greater than 4;
    - NEW with landmark_num==LM_MAX;
    - UPD/ASSOC with cmd_lk>=landmark_num.
    On reject go to REPORT with code 1 and issue nothing to the core. Otherwise latch l_k and go to ISSUE.
  - ISSUE: stage_val = code for exactly VAL_HOLD cycles, then 0; go to WAIT. Clear the timeout counter on entry.
  - WAIT: stage_val=0. If stage_rdy==issued code, go to REPORT with code 0.
    - On a NEW success, landmark_num increments in the same cycle REPORT is entered.
    - A stage_rdy value that is nonzero but does not match is ignored.
    - If the counter reaches TO_CYC-1 without a match, go to REPORT with code 2; landmark_num is unchanged.
  - REPORT (1 cycle): sts_val=1 with sts_stage/sts_code, then return to IDLE.
- Latency, accepted command on an empty FIFO: stage_val rises 3 cycles after acceptance (FIFO write, IDLE pop, CHECK).
- A stage_rdy pulse arriving during ISSUE counts as completion and is honoured on the first WAIT cycle. Because of this, stage_rdy is sampled into a sticky match flag from the first ISSUE cycle onward.
- Commands are executed strictly in FIFO order; there is one outstanding core operation at a time.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: EKF_SCHED_PERF_EN.
- When defined, adds output perf_cyc[31:0]: the cycle count from the first ISSUE cycle to the match or timeout, valid with sts_val and held until the next sts_val. Adds output perf_ovf, which is 1 if the count saturated at 0xFFFFFFFF.
- When undefined, neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package ekf_pkg:
  - stage codes IDLE/STAGE_PRD/STAGE_NEW/STAGE_UPD/STAGE_ASSOC;
  - status codes STS_OK/STS_REJ/STS_TO;
  - FSM state encoding.
- One sub-module, ekf_cmd_fifo: synchronous FIFO, width 3+ROW_LEN, depth FIFO_DEPTH, with full/empty flags. The FSM stays in ekf_stage_sched.

Test Plan:
- PRD after reset: push stage 1 → stage_val=1 for 2 cycles starting 3 cycles after acceptance. Drive stage_rdy=1 50 cycles later → sts_val with stage 1, code 0; landmark_num stays 0.
- UPD with no landmarks: push stage 3 with lk=2 while landmark_num=0 → sts code 1 within 3 cycles, stage_val never asserted.
- Three NEW commands, each completed, then UPD with lk=2 → landmark_num=3; the UPD is issued with l_k=2 and completes with code 0.
- Back-pressure: push 5 commands while the core withholds stage_rdy → cmd_rdy=0 after the 4th is buffered; commands then execute in order with matching sts_stage sequence.
- Timeout: with TO_CYC=16, issue ASSOC and never answer → sts code 2 on the expected cycle. A later stage_rdy=4 is ignored and the next command proceeds.
- Reset mid-WAIT: deassert sys_rst_n → all outputs return to reset values immediately and the FIFO is empty. With EKF_SCHED_PERF_EN, perf_cyc equals the known 50-cycle ISSUE-to-match delay of the PRD case.

Source files
------------

// File: rtl/ekf_pkg.sv
`default_nettype none
// ============================================================================
// Module : ekf_pkg
// Brief  : Stage codes, status codes and scheduler state encoding for the
//          EKF-SLAM stage sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package ekf_pkg;

  localparam logic [2:0] STAGE_IDLE  = 3'd0;
  localparam logic [2:0] STAGE_PRD   = 3'd1;
  localparam logic [2:0] STAGE_NEW   = 3'd2;
  localparam logic [2:0] STAGE_UPD   = 3'd3;
  localparam logic [2:0] STAGE_ASSOC = 3'd4;

  localparam logic [1:0] STS_OK  = 2'd0;
  localparam logic [1:0] STS_REJ = 2'd1;
  localparam logic [1:0] STS_TO  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4
  } sched_state_e;

  function automatic logic stage_known(input logic [2:0] stage);
    return (stage != STAGE_IDLE) && (stage <= STAGE_ASSOC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ekf_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : ekf_cmd_fifo
// Brief  : Synchronous command FIFO with full/empty flags (DEPTH power of 2).
// Rev    : 1.0 - initial release
// ============================================================================
module ekf_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/ekf_stage_sched.sv
`default_nettype none
// ============================================================================
// Module : ekf_stage_sched
// Brief  : Buffers host stage commands and drives the EKF core stage_val /
//          stage_rdy handshake, one operation at a time, with status report.
//          Optional macro EKF_SCHED_PERF_EN adds perf_cyc / perf_ovf.
// Rev    : 1.0 - initial release
// ============================================================================
module ekf_stage_sched
  import ekf_pkg::*;
#(
  parameter int ROW_LEN    = 10,
  parameter int LM_MAX     = 1000,
  parameter int FIFO_DEPTH = 4,
  parameter int VAL_HOLD   = 2,
  parameter int TO_CYC     = 4096,
  parameter int TO_W       = 13
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  input  logic [2:0]         cmd_stage,
  input  logic [ROW_LEN-1:0] cmd_lk,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] l_k,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic               busy,
  output logic               sts_val,
  output logic [2:0]         sts_stage,
  output logic [1:0]         sts_code
`ifdef EKF_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_cyc,
  output logic               perf_ovf
`endif
);

  sched_state_e         r_state;
  sched_state_e         w_next;
  logic [2:0]           r_stage;
  logic [ROW_LEN-1:0]   r_lk;
  logic [ROW_LEN-1:0]   r_l_k;
  logic [ROW_LEN-1:0]   r_lm_num;
  logic [1:0]           r_code;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_match;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [ROW_LEN+2:0]   w_head;
  logic                 w_reject;
  logic                 w_rdy_hit;
  logic                 w_match;
  logic                 w_hold_done;
  logic                 w_timeout;

  ekf_cmd_fifo #(
    .WIDTH (ROW_LEN + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rst_n),
    .push    (cmd_val),
    .wr_data ({cmd_stage, cmd_lk}),
    .pop     (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign cmd_rdy      = ~w_full;
  assign l_k          = r_l_k;
  assign landmark_num = r_lm_num;

  assign w_reject = !stage_known(r_stage)
                  || ((r_stage == STAGE_NEW) && (r_lm_num == ROW_LEN'(LM_MAX)))
                  || (((r_stage == STAGE_UPD) || (r_stage == STAGE_ASSOC)) && (r_lk >= r_lm_num));

  // A completion seen during ISSUE is remembered so WAIT can honour it.
  assign w_rdy_hit   = (stage_rdy == r_stage);
  assign w_match     = r_match | w_rdy_hit;
  assign w_hold_done = (r_to_cnt == TO_W'(VAL_HOLD - 1));
  assign w_timeout   = (r_to_cnt == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    stage_val = STAGE_IDLE;
    sts_val   = 1'b0;
    sts_stage = 3'd0;
    sts_code  = 2'd0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_CHECK;
        end
      end
      S_CHECK:  w_next = w_reject ? S_REPORT : S_ISSUE;
      S_ISSUE: begin
        stage_val = r_stage;
        if (w_hold_done) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_match || w_timeout) w_next = S_REPORT;
      end
      S_REPORT: begin
        sts_val   = 1'b1;
        sts_stage = r_stage;
        sts_code  = r_code;
        w_next    = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // One counter times both the stage_val hold and the stage_rdy timeout.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stage  <= 3'd0;
      r_lk     <= '0;
      r_l_k    <= '0;
      r_lm_num <= '0;
      r_code   <= 2'd0;
      r_to_cnt <= '0;
      r_match  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) {r_stage, r_lk} <= w_head;
        end
        S_CHECK: begin
          if (w_reject) begin
            r_code <= STS_REJ;
          end else begin
            r_l_k    <= r_lk;
            r_to_cnt <= '0;
            r_match  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_rdy_hit) r_match <= 1'b1;
        end
        S_WAIT: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_match) begin
            r_code <= STS_OK;
            if (r_stage == STAGE_NEW) r_lm_num <= r_lm_num + ROW_LEN'(1);
          end else if (w_timeout) begin
            r_code <= STS_TO;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EKF_SCHED_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_cyc;
  logic        r_perf_ovf;

  assign perf_cyc = r_perf_cyc;
  assign perf_ovf = r_perf_ovf;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_perf_cnt <= '0;
      r_perf_cyc <= '0;
      r_perf_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_CHECK: begin
          r_perf_cnt <= '0;
          if (w_reject) begin
            r_perf_cyc <= '0;
            r_perf_ovf <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_perf_cnt != '1) r_perf_cnt <= r_perf_cnt + 32'd1;
        end
        S_WAIT: begin
          if (r_perf_cnt != '1) r_perf_cnt <= r_perf_cnt + 32'd1;
          if (w_match || w_timeout) begin
            r_perf_cyc <= r_perf_cnt;
            r_perf_ovf <= &r_perf_cnt;
          end
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ekf_stage_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_ekf_stage_sched
// Brief  : Scoreboard bench for ekf_stage_sched with a responding core model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ekf_stage_sched;

  localparam int ROW_LEN  = 10;
  localparam int LM_MAX   = 6;
  localparam int DEPTH    = 4;
  localparam int VAL_HOLD = 2;
  localparam int TO_CYC   = 64;
  localparam int TO_W     = 7;

  typedef struct {
    logic [2:0]  stage;
    logic [1:0]  code;
    int          lm;
    int          perf;
  } exp_t;

  typedef struct {
    logic [2:0]  stage;
    int          lk;
    int          d;
  } plan_t;

  logic               clk;
  logic               sys_rst_n;
  logic               cmd_val;
  logic               cmd_rdy;
  logic [2:0]         cmd_stage;
  logic [ROW_LEN-1:0] cmd_lk;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;
  logic [ROW_LEN-1:0] l_k;
  logic [ROW_LEN-1:0] landmark_num;
  logic               busy;
  logic               sts_val;
  logic [2:0]         sts_stage;
  logic [1:0]         sts_code;
`ifdef EKF_SCHED_PERF_EN
  logic [31:0]        perf_cyc;
  logic               perf_ovf;
`endif

  ekf_stage_sched #(
    .ROW_LEN    (ROW_LEN),
    .LM_MAX     (LM_MAX),
    .FIFO_DEPTH (DEPTH),
    .VAL_HOLD   (VAL_HOLD),
    .TO_CYC     (TO_CYC),
    .TO_W       (TO_W)
  ) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .cmd_val      (cmd_val),
    .cmd_rdy      (cmd_rdy),
    .cmd_stage    (cmd_stage),
    .cmd_lk       (cmd_lk),
    .stage_val    (stage_val),
    .stage_rdy    (stage_rdy),
    .l_k          (l_k),
    .landmark_num (landmark_num),
    .busy         (busy),
    .sts_val      (sts_val),
    .sts_stage    (sts_stage),
    .sts_code     (sts_code)
`ifdef EKF_SCHED_PERF_EN
    ,
    .perf_cyc     (perf_cyc),
    .perf_ovf     (perf_ovf)
`endif
  );

  exp_t  sb[$];
  plan_t plan[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    m_lm    = 0;
  int    epoch   = 0;
  int    run     = 0;
  event  issue_ev;
  exp_t  mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_msg(input string name, input string msg);
    n_total++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference model: outcome follows from the command, the landmark count
  // at its turn in FIFO order, and the planned core response delay d
  // (cycles after the first stage_val cycle).
  task automatic push_cmd(input logic [2:0] st, input int lk, input int d);
    int    n;
    logic  bad;
    exp_t  e;
    plan_t p;
    @(negedge clk);
    cmd_val   = 1'b1;
    cmd_stage = st;
    cmd_lk    = ROW_LEN'(lk);
    n = 0;
    while (!cmd_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_rdy) begin
      fail_msg("push_timeout", "cmd_rdy stayed low for 500 cycles, required high");
      cmd_val = 1'b0;
      return;
    end
    bad = (st == 3'd0) || (st > 3'd4) || (st == 3'd2 && m_lm == LM_MAX)
       || ((st == 3'd3 || st == 3'd4) && lk >= m_lm);
    e.stage = st;
    if (bad) begin
      e.code = 2'd1;
      e.perf = 0;
    end else begin
      p.stage = st; p.lk = lk; p.d = d;
      plan.push_back(p);
      if (d <= TO_CYC - 1) begin
        e.code = 2'd0;
        e.perf = (d < VAL_HOLD) ? VAL_HOLD : d;
        if (st == 3'd2) m_lm++;
      end else begin
        e.code = 2'd2;
        e.perf = TO_CYC - 1;
      end
    end
    e.lm = m_lm;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_val = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || plan.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_msg("idle_timeout", "scheduler not idle after 3000 cycles, required idle");
    @(negedge clk);
  endtask

  task automatic rand_cmd();
    int r, st, lk, d;
    r = $urandom_range(0, 9);
    if (r <= 2)      st = 2;
    else if (r == 3) st = 1;
    else if (r <= 5) st = 3;
    else if (r <= 7) st = 4;
    else if (r == 8) st = $urandom_range(5, 7);
    else             st = 0;
    lk = $urandom_range(0, m_lm + 1);
    r = $urandom_range(0, 9);
    if (r < 6)       d = $urandom_range(0, 12);
    else if (r == 6) d = TO_CYC - 1;
    else if (r == 7) d = TO_CYC;
    else if (r == 8) d = TO_CYC + 1;
    else             d = $urandom_range(0, 1);
    push_cmd(3'(st), lk, d);
  endtask

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      run = 0;
    end else if (stage_val != 3'd0) begin
      if (run == 0) -> issue_ev;
      run++;
    end else if (run != 0) begin
      chk("val_hold", run, VAL_HOLD);
      run = 0;
    end
  end

  // Core model: answers each issue after its planned delay, sometimes
  // preceded by a non-matching nonzero code that must be ignored.
  initial begin : responder
    plan_t p;
    int    ep, g;
    logic [2:0] wrong;
    stage_rdy = 3'd0;
    forever begin
      @(issue_ev);
      ep = epoch;
      if (plan.size() == 0) begin
        fail_msg("unexpected_issue", $sformatf("stage_val=%0d with no planned issue", stage_val));
      end else begin
        p = plan.pop_front();
        chk("issue_stage", 32'(stage_val), 32'(p.stage));
        chk("issue_lk", 32'(l_k), 32'(p.lk));
        g = (p.d >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, p.d - 1) : -1;
        wrong = 3'($urandom_range(1, 7));
        if (wrong == p.stage) wrong = 3'((p.stage % 7) + 1);
        for (int k = 0; k <= p.d; k++) begin
          if (epoch != ep) break;
          stage_rdy = (k == p.d) ? p.stage : ((k == g) ? wrong : 3'd0);
          @(negedge clk);
        end
        stage_rdy = 3'd0;
      end
    end
  end

  always @(negedge clk) begin
    if (sys_rst_n && sts_val) begin
      if (sb.size() == 0) begin
        fail_msg("sts_unexpected", $sformatf("status stage=%0d code=%0d, required none", sts_stage, sts_code));
      end else begin
        mon_e = sb.pop_front();
        chk("sts_stage", 32'(sts_stage), 32'(mon_e.stage));
        chk("sts_code", 32'(sts_code), 32'(mon_e.code));
        chk("sts_landmark_num", 32'(landmark_num), 32'(mon_e.lm));
`ifdef EKF_SCHED_PERF_EN
        chk("perf_cyc", perf_cyc, 32'(mon_e.perf));
        chk("perf_ovf", 32'(perf_ovf), 32'd0);
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    sys_rst_n = 1'b0;
    cmd_val   = 1'b0;
    cmd_stage = 3'd0;
    cmd_lk    = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stage_val", 32'(stage_val), 32'd0);
    chk("rst_sts", 32'({sts_val, sts_stage, sts_code}), 32'd0);
    chk("rst_lm", 32'(landmark_num), 32'd0);
    chk("rst_lk", 32'(l_k), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // PRD, answered 50 cycles after the first issue cycle
    push_cmd(3'd1, 0, 50);
    n = 0;
    while (stage_val == 3'd0 && n < 20) begin @(negedge clk); n++; end
    chk("prd_latency", n, 3);
    wait_idle();

    // UPD with no landmarks is rejected
    push_cmd(3'd3, 2, 5);
    n = 0;
    while (!sts_val && n < 20) begin @(negedge clk); n++; end
    chk("rej_latency", n, 3);
    wait_idle();

    // three NEW then UPD lk=2
    for (int i = 0; i < 3; i++) push_cmd(3'd2, 0, $urandom_range(0, 10));
    push_cmd(3'd3, 2, 5);
    wait_idle();
    chk("lm_after_new", 32'(landmark_num), 32'd3);

    // back-pressure while the core is slow
    for (int i = 0; i < 5; i++) push_cmd(3'd1, 0, 20);
    @(negedge clk);
    chk("bp_full", 32'(cmd_rdy), 32'd0);
    push_cmd(3'd4, 1, 7);
    wait_idle();

    // timeout, late stale answer, next command proceeds
    push_cmd(3'd4, 0, TO_CYC + 1);
    n = 0;
    while (!sts_val && n < TO_CYC + 20) begin @(negedge clk); n++; end
    chk("to_latency", n, 3 + TO_CYC);
    push_cmd(3'd1, 0, 4);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      rand_cmd();
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    // landmark capacity boundary
    while (m_lm < LM_MAX) push_cmd(3'd2, 0, 1);
    push_cmd(3'd2, 0, 1);
    push_cmd(3'd3, LM_MAX - 1, 2);
    push_cmd(3'd3, LM_MAX, 2);
    wait_idle();
    chk("lm_max", 32'(landmark_num), 32'(LM_MAX));

    // reset during WAIT with commands still buffered
    push_cmd(3'd1, 0, TO_CYC + 1);
    push_cmd(3'd2, 0, 1);
    push_cmd(3'd3, 0, 1);
    n = 0;
    while (stage_val == 3'd0 && n < 20) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    sys_rst_n = 1'b0;
    epoch++;
    sb.delete();
    plan.delete();
    m_lm = 0;
    #1;
    chk("mid_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_stage_val", 32'(stage_val), 32'd0);
    chk("mid_rst_sts", 32'({sts_val, sts_stage, sts_code}), 32'd0);
    chk("mid_rst_lm", 32'(landmark_num), 32'd0);
    chk("mid_rst_lk", 32'(l_k), 32'd0);
    repeat (2) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_empty", 32'({busy, cmd_rdy}), 32'b01);

    for (int i = 0; i < 10; i++) rand_cmd();
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
